// File: rtl/io_arbiter_pkg.sv
// Shared I/O arbiter constants (mirrors the project-wide constants.v) and FSM state type.
// Macros are guarded so an earlier include of constants.v takes precedence.
`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 8
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 8
`endif
`ifndef IO_ARB_TIMEOUT
`define IO_ARB_TIMEOUT 16
`endif
`ifndef IO_ARB_IDLE
`define IO_ARB_IDLE 2'd0
`endif
`ifndef IO_ARB_ACCESS
`define IO_ARB_ACCESS 2'd1
`endif
`ifndef IO_ARB_DONE
`define IO_ARB_DONE 2'd2
`endif

package io_arbiter_pkg;

    localparam int ARB_ADDR_W  = `IO_ADDR_WIDTH;
    localparam int ARB_DATA_W  = `IO_DATA_WIDTH;
    localparam int ARB_TIMEOUT = `IO_ARB_TIMEOUT;

    typedef enum logic [1:0] {
        ARB_IDLE   = `IO_ARB_IDLE,
        ARB_ACCESS = `IO_ARB_ACCESS,
        ARB_DONE   = `IO_ARB_DONE
    } arb_state_e;

endpackage

// File: rtl/io_arb_timer.sv
// ACCESS-cycle counter; expired is high during the last permitted ACCESS cycle.
module io_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (enable && count_q != LAST)
            count_q <= count_q + 8'd1;
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter onto the slot bus with per-transaction timeout.
// Every output is registered; the comb process computes next values for all of them.
module io_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_read,
    output logic                  bus_write,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ready
);

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       gnt_q, gnt_d;
    logic       sel, wr_sel;
    logic       tmr_clear, tmr_en, tmr_expired;

    logic                  bus_read_d, bus_write_d;
    logic [ADDR_WIDTH-1:0] bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_d, rdata_d;
    logic                  m0_ack_d, m1_ack_d, m0_err_d, m1_err_d;

    io_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sel         = 1'b0;
        wr_sel      = 1'b0;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        bus_read_d  = bus_read;
        bus_write_d = bus_write;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        rdata_d     = rdata;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    // Pointer only breaks ties; a lone requester always wins.
                    sel         = (m0_req && m1_req) ? ptr_q : m1_req;
                    wr_sel      = sel ? m1_write : m0_write;
                    gnt_d       = sel;
                    bus_addr_d  = sel ? m1_addr : m0_addr;
                    bus_wdata_d = sel ? m1_wdata : m0_wdata;
                    bus_read_d  = !wr_sel;
                    bus_write_d = wr_sel;
                    tmr_clear   = 1'b1;
                    state_d     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                tmr_en = 1'b1;
                // bus_ready wins a same-cycle tie with expiry.
                if (bus_ready || tmr_expired) begin
                    if (bus_read)
                        rdata_d = bus_ready ? bus_rdata : '0;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    m0_ack_d    = !gnt_q;
                    m1_ack_d    = gnt_q;
                    m0_err_d    = !gnt_q && !bus_ready;
                    m1_err_d    = gnt_q && !bus_ready;
                    state_d     = ARB_DONE;
                end
            end
            ARB_DONE: begin
                ptr_d   = !gnt_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            bus_read  <= bus_read_d;
            bus_write <= bus_write_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            rdata     <= rdata_d;
            m0_ack    <= m0_ack_d;
            m1_ack    <= m1_ack_d;
            m0_err    <= m0_err_d;
            m1_err    <= m1_err_d;
        end
    end

endmodule
